// File: rtl/path_delay_scan_ctrl_pkg.sv
// path_delay_scan_ctrl_pkg: shared state encoding and default sizes
// for the path delay scan controller.
package path_delay_scan_ctrl_pkg;

  localparam int DEF_NUM_PATHS   = 4;
  localparam int DEF_PATH_W      = 2;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TRIALS      = 8;
  localparam int DEF_SETTLE_CYC  = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    LAUNCH,
    WAIT_EDGE,
    RELAX,
    NEXT_PATH,
    REPORT,
    DONE
  } state_e;

endpackage

// File: rtl/path_delay_scan_ctrl_if.sv
// path_delay_scan_ctrl_if: harness and chain-side signals of the scan
// controller. slave = controller view, master = harness/chain view.
interface path_delay_scan_ctrl_if
  import path_delay_scan_ctrl_pkg::*;
#(
  parameter int NUM_PATHS = DEF_NUM_PATHS,
  parameter int PATH_W    = DEF_PATH_W,
  parameter int CNT_W     = DEF_CNT_W
);
  logic                 start;
  logic [CNT_W-1:0]     golden_min;
  logic [CNT_W-1:0]     golden_max;
  logic [PATH_W-1:0]    path_sel;
  logic                 path_launch;
  logic [NUM_PATHS-1:0] path_result;
  logic                 busy;
  logic                 res_valid;
  logic [PATH_W-1:0]    res_path;
  logic [CNT_W-1:0]     res_delay;
  logic                 res_flag;
  logic                 done;

  modport slave (
    input  start, golden_min, golden_max, path_result,
    output path_sel, path_launch, busy,
    output res_valid, res_path, res_delay, res_flag, done
  );

  modport master (
    output start, golden_min, golden_max, path_result,
    input  path_sel, path_launch, busy,
    input  res_valid, res_path, res_delay, res_flag, done
  );
endinterface

// File: rtl/path_delay_scan_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer, async active-high reset to 0.
// Ports: clk, rst, d (async in), q (synced out).
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/path_delay_scan_ctrl.sv
// path_delay_scan_ctrl: launches edges into each delay chain, counts
// cycles to the output edge over TRIALS trials and flags sums outside
// [golden_min, golden_max]. Ports: clk, rst, bus (slave modport).
module path_delay_scan_ctrl
  import path_delay_scan_ctrl_pkg::*;
#(
  parameter int NUM_PATHS   = DEF_NUM_PATHS,
  parameter int PATH_W      = DEF_PATH_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TRIALS      = DEF_TRIALS,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic clk,
  input logic rst,
  path_delay_scan_ctrl_if.slave bus
);
  localparam int TR_W = $clog2(TRIALS + 1);
  localparam logic [CNT_W-1:0] SET_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_END = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [TR_W-1:0] TR_LAST = TR_W'(TRIALS - 1);
  localparam logic [PATH_W-1:0] P_LAST = PATH_W'(NUM_PATHS - 1);

  state_e            state;
  logic [PATH_W-1:0] path;
  logic [TR_W-1:0]   trial;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  wcnt;
  logic [CNT_W-1:0]  acc;
  logic              tmo;
  logic              obs;
  logic              raw;
  logic              launch;
  logic              busy;
  logic              rvalid;
  logic [PATH_W-1:0] rpath;
  logic [CNT_W-1:0]  rdelay;
  logic              rflag;
  logic              done;
  logic [CNT_W:0]    sum;
  logic [CNT_W-1:0]  acc_sat;

  assign raw = bus.path_result[path];

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw),
    .q   (obs)
  );

  assign sum     = {1'b0, acc} + {1'b0, cnt};
  assign acc_sat = sum[CNT_W] ? '1 : sum[CNT_W-1:0];

  assign bus.path_sel    = path;
  assign bus.path_launch = launch;
  assign bus.busy        = busy;
  assign bus.res_valid   = rvalid;
  assign bus.res_path    = rpath;
  assign bus.res_delay   = rdelay;
  assign bus.res_flag    = rflag;
  assign bus.done        = done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      path   <= '0;
      trial  <= '0;
      cnt    <= '0;
      wcnt   <= '0;
      acc    <= '0;
      tmo    <= 1'b0;
      launch <= 1'b0;
      busy   <= 1'b0;
      rvalid <= 1'b0;
      rpath  <= '0;
      rdelay <= '0;
      rflag  <= 1'b0;
      done   <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            path  <= '0;
            trial <= '0;
            acc   <= '0;
            tmo   <= 1'b0;
            wcnt  <= '0;
            busy  <= 1'b1;
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (wcnt >= SET_END && !obs) begin
            launch <= 1'b1;
            cnt    <= '0;
            state  <= LAUNCH;
          end else if (wcnt == TMO_END) begin
            tmo   <= 1'b1;
            state <= NEXT_PATH;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        LAUNCH: begin
          // launch is already high this cycle, so it counts
          cnt   <= CNT_W'(1);
          state <= WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (obs) begin
            acc    <= acc_sat;
            launch <= 1'b0;
            wcnt   <= '0;
            state  <= RELAX;
          end else if (cnt == TMO_END) begin
            tmo    <= 1'b1;
            launch <= 1'b0;
            state  <= NEXT_PATH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELAX: begin
          if (!obs) begin
            trial <= trial + 1'b1;
            wcnt  <= '0;
            state <= (trial == TR_LAST) ? REPORT : SETTLE;
          end else if (wcnt == TMO_END) begin
            tmo   <= 1'b1;
            state <= NEXT_PATH;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        NEXT_PATH: begin
          launch <= 1'b0;
          state  <= REPORT;
        end
        REPORT: begin
          rvalid <= 1'b1;
          rpath  <= path;
          rdelay <= acc;
          rflag  <= tmo | (acc < bus.golden_min)
                        | (acc > bus.golden_max);
          if (path == P_LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            path  <= path + 1'b1;
            trial <= '0;
            acc   <= '0;
            tmo   <= 1'b0;
            wcnt  <= '0;
            state <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_path_delay_scan_ctrl.sv
// tb_path_delay_scan_ctrl: models four delay chains and checks every
// reported result against a scoreboard of expected results.
module tb_path_delay_scan_ctrl;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int CW = 16;
  localparam int TR = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  path_delay_scan_ctrl_if #(
    .NUM_PATHS (NP),
    .PATH_W    (PW),
    .CNT_W     (CW)
  ) bus ();

  path_delay_scan_ctrl #(
    .NUM_PATHS   (NP),
    .PATH_W      (PW),
    .CNT_W       (CW),
    .TRIALS      (TR),
    .SETTLE_CYC  (16),
    .TIMEOUT_CYC (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int path;
    int delay;
    int flag;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // chain model: 0 = launch delayed dly cycles, 1 = stuck 0, 2 = stuck 1
  int mode[NP];
  int dly[NP];
  logic [15:0] sr[NP] = '{default: '0};
  logic [NP-1:0] chain;

  always @(posedge clk)
    for (int p = 0; p < NP; p++)
      sr[p] <= {sr[p][14:0],
                bus.path_launch && (bus.path_sel == PW'(p))};

  always_comb begin
    chain = '0;
    for (int p = 0; p < NP; p++)
      case (mode[p])
        1:       chain[p] = 1'b0;
        2:       chain[p] = 1'b1;
        default: chain[p] = sr[p][dly[p]-1];
      endcase
  end

  assign bus.path_result = chain;

  int nres = 0;
  int ndone = 0;
  int last_path = -1;
  bit launch_p0 = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (bus.path_launch && bus.path_sel == '0) launch_p0 = 1'b1;
    if (bus.res_valid) begin
      nres++;
      if (q.size() == 0) begin
        chk("unexpected_res", 1, 0);
      end else begin
        e = q.pop_front();
        chk("res_path", int'(bus.res_path), e.path);
        chk("res_delay", int'(bus.res_delay), e.delay);
        chk("res_flag", int'(bus.res_flag), e.flag);
      end
      last_path = int'(bus.res_path);
    end
    if (bus.done) begin
      ndone++;
      chk("done_after_last", last_path, NP - 1);
      chk("queue_empty_at_done", q.size(), 0);
    end
  end

  task automatic push_scan();
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      e.path = p;
      if (mode[p] == 0) begin
        e.delay = TR * (dly[p] + 2);
        e.flag = (e.delay < int'(bus.golden_min)) ||
                 (e.delay > int'(bus.golden_max));
      end else begin
        e.delay = 0;
        e.flag = 1;
      end
      q.push_back(e);
    end
  endtask

  task automatic start_scan();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    while (!bus.done && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, int'(bus.done), 1);
    @(negedge clk);
    chk({tag, "_busy_low"}, int'(bus.busy), 0);
    chk({tag, "_nres"}, nres, NP);
    chk({tag, "_ndone"}, ndone, 1);
  endtask

  task automatic wait_path(int p);
    int n = 0;
    while (!(bus.path_sel == PW'(p) && bus.path_launch) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_path", int'(bus.path_sel), p);
  endtask

  task automatic scan(string tag, int gmin, int gmax);
    bus.golden_min = CW'(gmin);
    bus.golden_max = CW'(gmax);
    nres = 0;
    ndone = 0;
    push_scan();
    start_scan();
    wait_done(tag);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_path_sel"}, int'(bus.path_sel), 0);
    chk({tag, "_launch"}, int'(bus.path_launch), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_res_valid"}, int'(bus.res_valid), 0);
    chk({tag, "_res_path"}, int'(bus.res_path), 0);
    chk({tag, "_res_delay"}, int'(bus.res_delay), 0);
    chk({tag, "_res_flag"}, int'(bus.res_flag), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
  endtask

  task automatic set_chains();
    for (int p = 0; p < NP; p++) mode[p] = 0;
    dly[0] = 5;
    dly[1] = 5;
    dly[2] = 9;
    dly[3] = 5;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.golden_min = CW'(50);
    bus.golden_max = CW'(60);
    set_chains();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    scan("main", 50, 60);
    scan("edge_in", 56, 88);
    scan("edge_out", 57, 87);
    scan("inverted", 60, 50);

    mode[1] = 1;
    scan("stuck0", 50, 60);
    set_chains();

    mode[0] = 2;
    launch_p0 = 1'b0;
    scan("stuck1", 50, 60);
    chk("stuck1_no_launch_p0", int'(launch_p0), 0);
    set_chains();

    bus.golden_min = CW'(50);
    bus.golden_max = CW'(60);
    nres = 0;
    ndone = 0;
    push_scan();
    start_scan();
    wait_path(1);
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    chk("restart_busy", int'(bus.busy), 1);
    wait_done("restart");

    nres = 0;
    ndone = 0;
    push_scan();
    start_scan();
    wait_path(2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    chk("midrst_pending", q.size(), 2);
    q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_res", nres, 2);
    scan("rescan", 50, 60);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
